// File: rtl/vga_ctrl.sv
// VGA timing generator: pixel-enable prescaler, raw h/v counters, sync decode and
// frame-RAM read strobe, all registered and aligned to the counter values.
module vga_ctrl #(
  parameter int        H_ACTIVE   = 640,
  parameter int        H_FP       = 16,
  parameter int        H_SYNC     = 96,
  parameter int        H_BP       = 48,
  parameter int        V_ACTIVE   = 480,
  parameter int        V_FP       = 10,
  parameter int        V_SYNC     = 2,
  parameter int        V_BP       = 33,
  parameter bit        SYNC_POL   = 1'b0,
  parameter int        CLK_DIV    = 2,
  parameter logic [7:0] DISP_STATE = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  state,
  output logic        spram_rd_sig,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [11:0] x_counter,
  output logic [11:0] y_counter,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic          pix_en;
  logic [11:0]   x_next;
  logic [11:0]   y_next;
  logic          act_next;
  logic          hs_next;
  logic          vs_next;

  function automatic logic in_window(input logic [11:0] v, input int lo, input int len);
    return (v >= 12'(lo)) && (v < 12'(lo + len));
  endfunction

  // Next counter values; every output is decoded from these so it lands with the counters
  always_comb begin
    pix_en = (presc == PRE_MAX);
    x_next = x_counter;
    y_next = y_counter;
    if (pix_en) begin
      if (x_counter == 12'(H_TOTAL - 1)) begin
        x_next = '0;
        y_next = (y_counter == 12'(V_TOTAL - 1)) ? 12'd0 : y_counter + 12'd1;
      end else begin
        x_next = x_counter + 12'd1;
      end
    end
    act_next = (x_next < 12'(H_ACTIVE)) && (y_next < 12'(V_ACTIVE));
    hs_next  = in_window(x_next, H_ACTIVE + H_FP, H_SYNC);
    vs_next  = in_window(y_next, V_ACTIVE + V_FP, V_SYNC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc        <= '0;
      x_counter    <= '0;
      y_counter    <= '0;
      xpos         <= '0;
      ypos         <= '0;
      spram_rd_sig <= 1'b0;
      VGA_HS       <= ~SYNC_POL;
      VGA_VS       <= ~SYNC_POL;
    end else begin
      presc     <= pix_en ? '0 : presc + PW'(1);
      x_counter <= x_next;
      y_counter <= y_next;
      xpos      <= act_next ? x_next : 12'd0;
      ypos      <= act_next ? y_next : 12'd0;
      VGA_HS    <= hs_next ? SYNC_POL : ~SYNC_POL;
      VGA_VS    <= vs_next ? SYNC_POL : ~SYNC_POL;
      // An unknown state must resolve to "no read", hence if/else rather than a direct assign
      if (act_next && (state == DISP_STATE))
        spram_rd_sig <= 1'b1;
      else
        spram_rd_sig <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Randomized bench for vga_ctrl: a default-mode instance and a small fast-frame
// instance are compared every cycle against an arithmetic timing model.
module tb_vga_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] state;

  logic        d_rd, d_hs, d_vs;
  logic [11:0] d_xp, d_yp, d_x, d_y;
  logic        s_rd, s_hs, s_vs;
  logic [11:0] s_xp, s_yp, s_x, s_y;

  int checks = 0;
  int errors = 0;

  // Small mode: 58 x 27 pixels, 3 clocks per pixel, active-high syncs
  localparam int S_HA = 40, S_HF = 4, S_HS = 8, S_HB = 6;
  localparam int S_VA = 20, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_DIV = 3;

  vga_ctrl u_dut (
    .clk(clk), .rst(rst), .state(state),
    .spram_rd_sig(d_rd), .xpos(d_xp), .ypos(d_yp),
    .x_counter(d_x), .y_counter(d_y), .VGA_HS(d_hs), .VGA_VS(d_vs)
  );

  vga_ctrl #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b1), .CLK_DIV(S_DIV), .DISP_STATE(8'h03)
  ) u_small (
    .clk(clk), .rst(rst), .state(state),
    .spram_rd_sig(s_rd), .xpos(s_xp), .ypos(s_yp),
    .x_counter(s_x), .y_counter(s_y), .VGA_HS(s_hs), .VGA_VS(s_vs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Position after n clock edges since reset release: one pixel per div clocks
  function automatic void model_pos(input int n, input int ht, input int vt, input int div,
                                    output int x, output int y);
    int p;
    p = n / div;
    x = p % ht;
    y = (p / ht) % vt;
  endfunction

  task automatic check_unit(input string nm, input int n, input logic [7:0] st,
                            input int ha, input int hf, input int hs, input int hb,
                            input int va, input int vf, input int vs, input int vb,
                            input int div, input bit pol,
                            input logic [11:0] x, input logic [11:0] y,
                            input logic [11:0] xp, input logic [11:0] yp,
                            input logic hsync, input logic vsync, input logic rd);
    int  ex, ey;
    bit  act, hin, vin;
    model_pos(n, ha + hf + hs + hb, va + vf + vs + vb, div, ex, ey);
    act = (ex < ha) && (ey < va);
    hin = (ex >= ha + hf) && (ex < ha + hf + hs);
    vin = (ey >= va + vf) && (ey < va + vf + vs);
    chk($sformatf("%s_x@%0d", nm, n), 32'(x), 32'(ex));
    chk($sformatf("%s_y@%0d", nm, n), 32'(y), 32'(ey));
    chk($sformatf("%s_xpos@%0d", nm, n), 32'(xp), act ? 32'(ex) : 32'd0);
    chk($sformatf("%s_ypos@%0d", nm, n), 32'(yp), act ? 32'(ey) : 32'd0);
    chk($sformatf("%s_hs@%0d", nm, n), 32'(hsync), hin ? 32'(pol) : 32'(!pol));
    chk($sformatf("%s_vs@%0d", nm, n), 32'(vsync), vin ? 32'(pol) : 32'(!pol));
    chk($sformatf("%s_rd@%0d", nm, n), 32'(rd), (n > 0 && act && st === 8'h03) ? 32'd1 : 32'd0);
  endtask

  task automatic check_both(input int n, input logic [7:0] st);
    check_unit("dflt", n, st, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0,
               d_x, d_y, d_xp, d_yp, d_hs, d_vs, d_rd);
    check_unit("small", n, st, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_DIV, 1'b1,
               s_x, s_y, s_xp, s_yp, s_hs, s_vs, s_rd);
  endtask

  initial begin
    int         n;
    logic [7:0] st_s;
    bit         did_rst;
    int         mx, my;
    logic [7:0] rv;

    rst     = 1'b1;
    state   = 8'h00;
    did_rst = 1'b0;
    #2;
    check_both(0, 8'h00);
    #3 state = 8'h03;
    @(negedge clk);
    check_both(0, 8'h00);
    rst  = 1'b0;
    n    = 0;
    st_s = 8'h00;

    for (int cyc = 0; cyc < 60000; cyc++) begin
      @(posedge clk);
      n++;
      st_s = state;
      @(negedge clk);
      check_both(n, st_s);

      model_pos(n, 800, 525, 2, mx, my);
      if (!did_rst && n > 20000 && mx == 300) begin
        did_rst = 1'b1;
        #2 rst = 1'b1;
        #1 check_both(0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check_both(0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n   = 0;
      end

      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 3))
          0: state = 8'h03;
          1: state = 8'h00;
          2: state = 8'hxx;
          default: begin
            rv    = 8'($urandom);
            state = rv;
          end
        endcase
      end
    end

    chk("reset_exercised", 32'(did_rst), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
